// File: rtl/outport_display_if.sv
// Outport write channel and seven-segment display outputs of outport_display_ctrl.
// The master side writes values and the slave side drives the display.
interface outport_display_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 4
);
  logic                    in_write;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_mode;
  logic                    in_blank_lz;
  logic [7*NUM_DIGITS-1:0] out_segments;
  logic                    out_busy;
  logic                    out_overflow;

  modport master (
    output in_write, in_data, in_mode, in_blank_lz,
    input  out_segments, out_busy, out_overflow
  );

  modport slave (
    input  in_write, in_data, in_mode, in_blank_lz,
    output out_segments, out_busy, out_overflow
  );
endinterface

// File: rtl/outport_display_ctrl.sv
// Seven-segment driver for the CPU outport: hex or decimal (sequential double-dabble),
// with leading-zero blanking, overflow dashes and a one-deep pending write buffer.
module outport_display_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  outport_display_if.slave   bus
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int EXT_W = BCD_W + DATA_WIDTH;
  localparam logic [4:0] CNT_LAST = 5'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  mode_r, blank_r;
  logic                  pend_valid_r, pend_mode_r, pend_blank_r;
  logic [DATA_WIDTH-1:0] pend_data_r;
  logic [BCD_W-1:0]      bcd_r, adj_s;
  logic                  sticky_r;
  logic [4:0]            cnt_r;
  logic [SEG_W-1:0]      seg_r, seg_next_s;
  logic                  ovf_r, ovf_next_s, busy_r;
  logic                  launch_s, pend_take_s;
  logic [DATA_WIDTH-1:0] launch_data_s;
  logic                  launch_mode_s, launch_blank_s;
  logic [EXT_W-1:0]      ext_s;
  logic                  hex_ovf_s;
  logic [3:0]            nib_s;
  logic                  nz_seen_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      4'hF: hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h3F;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Next state and job launch; a pending write left over in IDLE is drained, newest wins
  always_comb begin
    state_next_s   = state_r;
    launch_s       = 1'b0;
    pend_take_s    = 1'b0;
    launch_data_s  = bus.in_data;
    launch_mode_s  = bus.in_mode;
    launch_blank_s = bus.in_blank_lz;
    case (state_r)
      ST_IDLE: begin
        pend_take_s = pend_valid_r;
        if (bus.in_write) begin
          launch_s = 1'b1;
        end else if (pend_valid_r) begin
          launch_s       = 1'b1;
          launch_data_s  = pend_data_r;
          launch_mode_s  = pend_mode_r;
          launch_blank_s = pend_blank_r;
        end else begin
          launch_s = 1'b0;
        end
        if (launch_s) state_next_s = launch_mode_s ? ST_CONVERT : ST_LOAD;
        else          state_next_s = ST_IDLE;
      end
      ST_CONVERT: begin
        if (cnt_r == CNT_LAST) state_next_s = ST_LOAD;
        else                   state_next_s = ST_CONVERT;
      end
      ST_LOAD: begin
        if (pend_valid_r) begin
          launch_s       = 1'b1;
          pend_take_s    = 1'b1;
          launch_data_s  = pend_data_r;
          launch_mode_s  = pend_mode_r;
          launch_blank_s = pend_blank_r;
          state_next_s   = pend_mode_r ? ST_CONVERT : ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Pending buffer: writes arriving while busy, overwritten by newer ones
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid_r <= 1'b0;
      pend_data_r  <= '0;
      pend_mode_r  <= 1'b0;
      pend_blank_r <= 1'b0;
    end else if (bus.in_write && (state_r != ST_IDLE)) begin
      pend_valid_r <= 1'b1;
      pend_data_r  <= bus.in_data;
      pend_mode_r  <= bus.in_mode;
      pend_blank_r <= bus.in_blank_lz;
    end else if (pend_take_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  // Double-dabble add-3 correction on every BCD digit
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      else                         adj_s[4*i +: 4] = bcd_r[4*i +: 4];
    end
  end

  // Working register and conversion datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r   <= '0;
      mode_r   <= 1'b0;
      blank_r  <= 1'b0;
      bcd_r    <= '0;
      sticky_r <= 1'b0;
      cnt_r    <= 5'd0;
    end else if (launch_s) begin
      data_r   <= launch_data_s;
      mode_r   <= launch_mode_s;
      blank_r  <= launch_blank_s;
      bcd_r    <= '0;
      sticky_r <= 1'b0;
      cnt_r    <= 5'd0;
    end else if (state_r == ST_CONVERT) begin
      data_r   <= data_r << 1;
      bcd_r    <= {adj_s[BCD_W-2:0], data_r[DATA_WIDTH-1]};
      sticky_r <= sticky_r | adj_s[BCD_W-1];
      cnt_r    <= cnt_r + 5'd1;
    end
  end

  assign ext_s     = EXT_W'(data_r);
  assign hex_ovf_s = |(ext_s >> BCD_W);

  // Display image: digit select, dashes on overflow, blanking above the top nonzero digit
  always_comb begin
    seg_next_s = '0;
    nib_s      = 4'h0;
    nz_seen_s  = 1'b0;
    ovf_next_s = mode_r ? sticky_r : hex_ovf_s;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib_s = mode_r ? bcd_r[4*i +: 4] : ext_s[4*i +: 4];
      if (nib_s != 4'h0) nz_seen_s = 1'b1;
      else               nz_seen_s = nz_seen_s;
      if (ovf_next_s)                            seg_next_s[7*i +: 7] = 7'h3F;
      else if (blank_r && !nz_seen_s && (i != 0)) seg_next_s[7*i +: 7] = 7'h7F;
      else                                       seg_next_s[7*i +: 7] = hex_to_seg(nib_s);
    end
  end

  // Registered outputs; display only changes in LOAD
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_r  <= {NUM_DIGITS{7'h40}};
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      if (state_r == ST_LOAD) begin
        seg_r <= seg_next_s;
        ovf_r <= ovf_next_s;
      end
    end
  end

  assign bus.out_segments = seg_r;
  assign bus.out_overflow = ovf_r;
  assign bus.out_busy     = busy_r;
endmodule

// File: tb/tb_outport_display_ctrl.sv
// Directed bench for outport_display_ctrl: per-cycle comparison against a transaction-level
// display model, plus hand-computed literal expectations.
module tb_outport_display_ctrl;
  localparam int DW = 16;
  localparam int ND = 4;
  localparam int SW = 7 * ND;
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [SW-1:0] SEG_TWO = {7'h40, 7'h40, 7'h40, 7'h24};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  outport_display_if #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) bus();
  outport_display_ctrl #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit watch_two = 1'b0;
  bit saw_two = 1'b0;

  function automatic bit exp_ovf(longint unsigned v, bit dec);
    longint unsigned p = 1;
    for (int i = 0; i < ND; i++) p = p * 10;
    if (dec) return v >= p;
    return (v >> (4 * ND)) != 0;
  endfunction

  function automatic logic [SW-1:0] exp_seg(longint unsigned v, bit dec, bit blank);
    int d[ND];
    int msd = 0;
    longint unsigned p = 1;
    logic [SW-1:0] r = '0;
    if (exp_ovf(v, dec)) return {ND{7'h3F}};
    for (int i = 0; i < ND; i++) begin
      d[i] = dec ? int'((v / p) % 10) : int'((v >> (4 * i)) & 15);
      p = p * 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = (blank && i > msd) ? 7'h7F : SEG_TAB[d[i]];
    return r;
  endfunction

  // Transaction-level model: a job shows its result 1 (hex) or DW+1 (decimal) edges after it starts
  bit m_active = 0, m_pv = 0, m_jd = 0, m_jb = 0, m_pd = 0, m_pb = 0, m_ovf = 0, m_busy = 0;
  int m_rem = 0;
  longint unsigned m_jv = 0, m_pvv = 0;
  logic [SW-1:0] m_seg = '0;

  task automatic m_start(longint unsigned v, bit d, bit b);
    m_active = 1; m_jv = v; m_jd = d; m_jb = b;
    m_rem = d ? DW + 1 : 1;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 0; m_pv = 0; m_seg = {ND{7'h40}}; m_ovf = 0;
    end else if (!m_active) begin
      if (bus.in_write) begin
        m_start(64'(bus.in_data), bus.in_mode, bus.in_blank_lz);
        m_pv = 0;
      end else if (m_pv) begin
        m_start(m_pvv, m_pd, m_pb);
        m_pv = 0;
      end
    end else begin
      if (m_rem == 1) begin
        m_seg = exp_seg(m_jv, m_jd, m_jb);
        m_ovf = exp_ovf(m_jv, m_jd);
        if (m_pv) begin
          m_start(m_pvv, m_pd, m_pb);
          m_pv = 0;
        end else m_active = 0;
      end else m_rem--;
      if (bus.in_write) begin
        m_pv = 1; m_pvv = 64'(bus.in_data); m_pd = bus.in_mode; m_pb = bus.in_blank_lz;
      end
    end
    m_busy = m_active;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (bus.out_segments !== m_seg || bus.out_busy !== m_busy || bus.out_overflow !== m_ovf) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t seg=%h want %h busy=%b want %b ovf=%b want %b",
                 $time, bus.out_segments, m_seg, bus.out_busy, m_busy, bus.out_overflow, m_ovf);
      end
      if (watch_two && bus.out_segments === SEG_TWO) saw_two = 1'b1;
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic [DW-1:0] d, bit dec, bit blank);
    bus.in_write = 1'b1; bus.in_data = d; bus.in_mode = dec; bus.in_blank_lz = blank;
    step();
    bus.in_write = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.out_busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout got=%0d cycles want<200", n);
    end
  endtask

  task automatic check_disp(string name, logic [SW-1:0] want, bit want_ovf);
    check({name, "_seg"}, 64'(bus.out_segments), 64'(want));
    check({name, "_ovf"}, 64'(bus.out_overflow), 64'(want_ovf));
    check({name, "_model"}, 64'(m_seg), 64'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_write = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0; bus.in_blank_lz = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;
    check_disp("reset", {ND{7'h40}}, 1'b0);
    check("reset_busy", 64'(bus.out_busy), 64'd0);
    reset = 1'b1;
    step();

    pulse(16'h1A3F, 1'b0, 1'b0);
    wait_idle(n);
    check("hex_busy_cycles", 64'(n), 64'd1);
    check_disp("hex_1a3f", {7'h79, 7'h08, 7'h30, 7'h0E}, 1'b0);

    pulse(16'd1234, 1'b1, 1'b0);
    wait_idle(n);
    check("dec_busy_cycles", 64'(n), 64'd17);
    check_disp("dec_1234", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0);

    pulse(16'd10000, 1'b1, 1'b0);
    wait_idle(n);
    check_disp("dec_ovf", {ND{7'h3F}}, 1'b1);
    pulse(16'h0005, 1'b0, 1'b1);
    wait_idle(n);
    check_disp("hex_blank5", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0);

    pulse(16'd7, 1'b1, 1'b1);
    wait_idle(n);
    check_disp("dec_blank7", {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0);
    pulse(16'd0, 1'b1, 1'b1);
    wait_idle(n);
    check_disp("dec_blank0", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);

    // Back-to-back writes at edges 0, 3 and 5
    watch_two = 1'b1;
    pulse(16'd1, 1'b1, 1'b0);
    step(); step();
    pulse(16'd2, 1'b1, 1'b0);
    step();
    pulse(16'd3, 1'b1, 1'b0);
    repeat (12) step();
    check_disp("b2b_first", {7'h40, 7'h40, 7'h40, 7'h79}, 1'b0);
    check("b2b_busy_mid", 64'(bus.out_busy), 64'd1);
    wait_idle(n);
    check("b2b_busy_tail", 64'(n), 64'd17);
    check_disp("b2b_last", {7'h40, 7'h40, 7'h40, 7'h30}, 1'b0);
    check("b2b_never_two", 64'(saw_two), 64'd0);
    watch_two = 1'b0;

    // Reset sampled at edge 8 of a 9999 conversion
    pulse(16'd9999, 1'b1, 1'b0);
    repeat (7) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_disp("abort", {ND{7'h40}}, 1'b0);
    check("abort_busy", 64'(bus.out_busy), 64'd0);
    step();
    pulse(16'd9999, 1'b1, 1'b0);
    wait_idle(n);
    check("rerun_busy_cycles", 64'(n), 64'd17);
    check_disp("rerun_9999", {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/outport_display_ctrl.md
Name: outport_display_ctrl

Overview:
- Parametrised seven-segment driver for the CPU output port. Replaces the fixed two-digit, hex-only decode.
- Latches outport writes and drives NUM_DIGITS displays in one of two modes: hexadecimal, or unsigned decimal via a sequential double-dabble converter.
- Supports leading-zero blanking and overflow indication, and has a one-deep pending buffer so back-to-back outport writes are not lost.
- Sits between the datapath outport register and the board HEX pins, clocked from the divided system clock.

Parameters:
- DATA_WIDTH, 16: width of written value; legal range 4..32.
- NUM_DIGITS, 4: number of seven-segment digits driven; legal range 1..8.

Ports:
- clk  input  1  system clock (divided clock); all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_write  input  1  one-cycle strobe; in_data/in_mode/in_blank_lz are valid with it.
- in_data  input  DATA_WIDTH  unsigned value to display.
- in_mode  input  1  0 = hex, 1 = decimal.
- in_blank_lz  input  1  1 = blank leading zero digits.
- out_segments  output  7*NUM_DIGITS  active-low segments. Digit i occupies [7i+6:7i], bit order {g,f,e,d,c,b,a}; digit 0 is least significant.
- out_busy  output  1  high whenever state != IDLE.
- out_overflow  output  1  high while the displayed value does not fit; updated at LOAD.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, pending buffer cleared.
  - out_segments = every digit 7'h40 (shows "0").
  - out_busy=0, out_overflow=0.
  - Reset wins over everything and aborts any conversion in progress; no partial result is ever shown.
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE, in_write=1: capture data/mode/blank_lz into the working register. Go to LOAD if hex, CONVERT if decimal.
  - CONVERT: one double-dabble iteration per cycle, exactly DATA_WIDTH cycles (5-bit counter), then go to LOAD.
    - Each iteration: add 3 to every BCD digit >=5, then shift the BCD register (4*NUM_DIGITS bits) left by 1, taking the binary MSB.
    - Any 1 shifted out of the top BCD bit sets a sticky overflow flag.
  - LOAD: register the new out_segments and out_overflow. Next state:
    - if pending is valid: consume it and go straight to CONVERT or LOAD by its mode;
    - else go to IDLE.
- Latency, with the write sampled at edge 0:
  - hex: outputs update at edge 1.
  - decimal: outputs update at edge DATA_WIDTH+1.
  - out_busy is high from after edge 0 until the edge that returns to IDLE.
- Pending buffer:
  - in_write while state != IDLE stores the write in pending and sets pending valid. A later write overwrites an older pending write (newest wins).
  - A write in the same cycle LOAD consumes pending becomes the new pending entry.
- Hex mode:
  - Digit i = in_data[4i+3:4i]; bits beyond DATA_WIDTH read as 0.
  - Overflow = 1 if any in_data bit at position >= 4*NUM_DIGITS is set.
- Encoding (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Overflow display: every digit shows a dash (7'h3F) and out_overflow=1. Blanking does not apply.
- Blanking:
  - When in_blank_lz is set, every digit above the most-significant nonzero digit shows 7'h7F.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- The outputs hold their value in IDLE and during CONVERT, so the display never flickers mid-conversion.

Test Plan:
1. Hex, DATA_WIDTH=16, NUM_DIGITS=4: write 0x1A3F -> after 1 edge, digits3..0 = 79,08,30,0E; overflow=0; busy pulses for 1 cycle.
2. Decimal, write 1234 (0x04D2) -> busy for 17 cycles; then digits = 79,24,30,19; overflow=0.
3. Decimal, write 10000 -> all digits 3F, overflow=1. Follow with hex write 0x0005 and blank_lz=1 -> 7F,7F,7F,12; overflow=0.
4. Decimal with blank_lz, write 7 -> 7F,7F,7F,78. Write 0 -> 7F,7F,7F,40.
5. Back-to-back: decimal 1 at cycle 0, decimal 2 at cycle 3, decimal 3 at cycle 5 -> "1" is displayed, then "3"; "2" is never displayed; busy is continuous until "3" loads.
6. Mid-conversion reset: assert reset at cycle 8 of a conversion of 9999 -> outputs return to all 40, busy=0; the "9999" result never appears; a new write afterwards converts normally.
